// File: rtl/bit_packer_pkg.sv
// Shared constants and FSM state type for the MSB-first variable-length bit packer.
package bit_packer_pkg;

  localparam int MAX_CODE_LEN = 18;
  localparam int ACC_W        = 32;
  localparam int ACCEPT_LIMIT = 14;
  localparam int CNT_W        = 6;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    PAD   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bit_packer.sv
// MSB-first packer of 0..18-bit codes into bytes, with flush/pad of the final partial byte.
// Optional BIT_PACKER_STATS_EN adds the stat_bits running total of accepted code bits.
module bit_packer
  import bit_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [17:0]      code_data,
  input  logic [4:0]       code_len,
  input  logic             code_valid,
  output logic             code_ready,
  input  logic             flush_req,
  output logic             flush_done,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef BIT_PACKER_STATS_EN
  output logic [31:0]      stat_bits,
`endif
  output state_t           dbg_state,
  output logic [CNT_W-1:0] dbg_bit_cnt
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high
  // at the rising clock edge; valid never depends on ready in this block.

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt, acc_shift, code_left;
  logic [CNT_W-1:0]   bit_cnt, cnt_nxt, cnt_shift;
  logic [4:0]         len_c;
  logic [17:0]        code_mask;
  logic               accept, emit;

  always_comb begin
    len_c      = (code_len > 5'(MAX_CODE_LEN)) ? 5'(MAX_CODE_LEN) : code_len;
    code_mask  = 18'((19'd1 << len_c) - 19'd1);
    // Left-align the masked code so its first bit lands at acc[31].
    code_left  = {code_data & code_mask, 14'd0} << (5'(MAX_CODE_LEN) - len_c);

    code_ready = (state == RUN) && (bit_cnt <= CNT_W'(ACCEPT_LIMIT));
    out_valid  = (bit_cnt >= CNT_W'(8)) || (state == PAD);
    out_data   = acc[ACC_W-1 -: 8];
    if (state == PAD) out_data = acc[ACC_W-1 -: 8] & ~(8'hFF >> bit_cnt);
    flush_done = (state == DONE);

    accept     = code_valid && code_ready;
    emit       = out_valid && out_ready;

    acc_shift  = emit ? (acc << 8) : acc;
    cnt_shift  = emit ? (bit_cnt - CNT_W'(8)) : bit_cnt;
    acc_nxt    = accept ? (acc_shift | (code_left >> cnt_shift)) : acc_shift;
    cnt_nxt    = accept ? (cnt_shift + CNT_W'(len_c)) : cnt_shift;
    state_nxt  = state;

    case (state)
      RUN:   if (flush_req) state_nxt = DRAIN;
      DRAIN: begin
        if (bit_cnt == '0)                state_nxt = DONE;
        else if (bit_cnt < CNT_W'(8))     state_nxt = PAD;
      end
      PAD: begin
        // bit_cnt < 8 here, so the generic shift path must not be used.
        if (emit) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        acc_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      acc     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

`ifdef BIT_PACKER_STATS_EN
  logic [31:0] stat_cnt;

  always_ff @(posedge clk) begin
    if (rst)         stat_cnt <= '0;
    else if (accept) stat_cnt <= stat_cnt + 32'(len_c);
  end

  assign stat_bits = stat_cnt;
`endif

  assign dbg_state   = state;
  assign dbg_bit_cnt = bit_cnt;

endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: directed scenarios plus random traffic against a bit-queue reference model.
module tb_bit_packer;
  import bit_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] code_data = '0;
  logic [4:0]  code_len = '0;
  logic        code_valid = 1'b0;
  logic        code_ready;
  logic        flush_req = 1'b0;
  logic        flush_done;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef BIT_PACKER_STATS_EN
  logic [31:0] stat_bits;
`endif
  state_t      dbg_state;
  logic [5:0]  dbg_bit_cnt;

  bit_packer dut (
    .clk(clk), .rst(rst),
    .code_data(code_data), .code_len(code_len), .code_valid(code_valid),
    .code_ready(code_ready), .flush_req(flush_req), .flush_done(flush_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef BIT_PACKER_STATS_EN
    .stat_bits(stat_bits),
`endif
    .dbg_state(dbg_state), .dbg_bit_cnt(dbg_bit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pending bits in stream order, oldest first.
  logic [0:0]  exp_q[$];
  int unsigned stat_exp = 0;
  bit          flushing = 1'b0;
  int          flush_age = 0;
  int          done_seen = 0;
  logic [7:0]  last_byte = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] head_byte();
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++)
      if (i < exp_q.size()) b[7-i] = exp_q[i];
    return b;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic v, input logic [17:0] d, input logic [4:0] l,
                       input logic f, input logic r);
    bit exp_ready;
    bit was_flushing;
    int lc;
    int n;
    code_valid = v; code_data = d; code_len = l; flush_req = f; out_ready = r;
    #1;
    if (rst) begin
      exp_q.delete();
      flushing  = 1'b0;
      flush_age = 0;
      stat_exp  = 0;
    end else begin
      was_flushing = flushing;
      exp_ready = !flushing && (exp_q.size() <= ACCEPT_LIMIT);
      check("code_ready", code_ready, exp_ready);
      check("bit_cnt", dbg_bit_cnt, exp_q.size());
      if (!flushing) check("state", dbg_state, RUN);
      if (exp_q.size() >= 8) begin
        check("out_valid", out_valid, 1);
        check("out_data", out_data, head_byte());
      end else if (exp_q.size() == 0) begin
        check("out_valid", out_valid, 0);
        check("out_data_zero", out_data, 0);
      end else if (!flushing) begin
        check("out_valid", out_valid, 0);
      end else if (out_valid) begin
        check("pad_data", out_data, head_byte());
      end
      if (!flushing) check("flush_done", flush_done, 0);
      else if (flush_done) begin
        check("flush_empty", exp_q.size(), 0);
        done_seen++;
      end
`ifdef BIT_PACKER_STATS_EN
      check("stat_bits", stat_bits, stat_exp);
`endif
      if (out_valid && out_ready) begin
        last_byte = head_byte();
        n = (exp_q.size() < 8) ? exp_q.size() : 8;
        repeat (n) void'(exp_q.pop_front());
      end
      if (v && exp_ready) begin
        lc = (l > 18) ? 18 : int'(l);
        for (int i = lc - 1; i >= 0; i--) exp_q.push_back(d[i]);
        stat_exp += lc;
      end
      if (was_flushing && flush_done) begin
        flushing  = 1'b0;
        flush_age = 0;
      end else if (was_flushing) begin
        flush_age++;
        if (flush_age > 200) begin
          check("flush_timeout", flush_age, 0);
          flushing  = 1'b0;
          flush_age = 0;
        end
      end
      if (f && !was_flushing) flushing = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int cycles, input logic r);
    repeat (cycles) cycle(1'b0, '0, '0, 1'b0, r);
  endtask

  task automatic do_flush();
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    idle(8, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    idle(2, 1'b0);
    rst = 1'b0;
    idle(1, 1'b0);

    // Two codes forming one byte plus 3 leftover bits, then a flush pads them.
    cycle(1'b1, 18'h03, 5'd5, 1'b0, 1'b1);
    cycle(1'b1, 18'h21, 5'd6, 1'b0, 1'b1);
    idle(2, 1'b1);
    check("s1_byte", last_byte, 8'h1C);
    check("s1_bits", dbg_bit_cnt, 3);
    done_seen = 0;
    do_flush();
    check("s2_pad", last_byte, 8'h20);
    check("s2_done_pulse", done_seen, 1);
    check("s2_bits", dbg_bit_cnt, 0);

    // Backpressure with long codes.
    for (int i = 0; i < 4; i++) cycle(1'b1, 18'h3FFFF, 5'd18, 1'b0, 1'b0);
    check("s3_cnt", dbg_bit_cnt, 18);
    check("s3_hold", out_data, 8'hFF);
    idle(3, 1'b0);
    check("s3_hold_late", out_data, 8'hFF);
    idle(3, 1'b1);
    do_flush();

    // Streaming byte-sized codes: one byte per cycle.
    for (int i = 0; i < 20; i++) cycle(1'b1, 18'($urandom_range(0, 255)), 5'd8, 1'b0, 1'b1);
    idle(2, 1'b1);
    do_flush();

    // Length clamp and zero-length codes.
    cycle(1'b1, 18'h3FFFF, 5'd25, 1'b0, 1'b0);
    check("s5_clamp", dbg_bit_cnt, 18);
    cycle(1'b1, 18'($urandom), 5'd0, 1'b0, 1'b0);
    check("s5_zero", dbg_bit_cnt, 18);
    do_flush();

    // Reset in the middle of a flush with 12 bits pending.
    cycle(1'b1, 18'h0ABC, 5'd12, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    idle(2, 1'b0);
    check("s6_drain", dbg_state, DRAIN);
    rst = 1'b1;
    idle(1, 1'b1);
    rst = 1'b0;
    check("s6_state", dbg_state, RUN);
    check("s6_valid", out_valid, 0);
    check("s6_ready", code_ready, 1);
`ifdef BIT_PACKER_STATS_EN
    check("s6_stats", stat_bits, 0);
`endif
    idle(2, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 1)), 18'($urandom), 5'($urandom_range(0, 24)),
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0));
    do_flush();
    idle(4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
